// File: rtl/spw_pll_ctrl_pkg.sv
// Shared types and constants for the SpaceWire TX PLL sequencer.
package spw_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL  = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE_CHK = 3'd2,
    RUN        = 3'd3,
    GATE       = 3'd4,
    SWITCH     = 3'd5,
    SETTLE     = 3'd6,
    FAULT      = 3'd7
  } pll_state_e;

  localparam logic [2:0] SEL_5M   = 3'd0;
  localparam logic [2:0] SEL_10M  = 3'd1;
  localparam logic [2:0] SEL_50M  = 3'd2;
  localparam logic [2:0] SEL_100M = 3'd3;
  localparam logic [2:0] SEL_200M = 3'd4;
  localparam int         NUM_TX_CLKS = 5;
  localparam logic [2:0] SEL_LAST = SEL_200M;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spw_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module spw_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/spw_ulight_pll_tx_ctrl.sv
// TX PLL sequencer: PLL reset/lock/retry handling and gated TX rate switching.
// state      | meaning
// RESET_PLL  | pll_rst pulse
// WAIT_LOCK  | wait for lock, timeout -> retry or fault
// STABLE_CHK | lock must hold for LOCK_STABLE cycles
// RUN        | clocks up, rate requests accepted
// GATE       | tx_clk_en low before the select change
// SWITCH     | new select applied
// SETTLE     | tx_clk_en low after the select change
// FAULT      | terminal lock failure
module spw_ulight_pll_tx_ctrl
  import spw_pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 256,
  parameter int GATE_CYCLES  = 8,
  parameter int MAX_RETRY    = 3,
  parameter int DEFAULT_SEL  = 1
) (
  input  logic                               i_refclk,
  input  logic                               i_rst,
  input  logic                               i_pll_locked,
  output logic                               o_pll_rst,
  input  logic                               i_rate_req,
  input  logic [2:0]                         i_rate_sel,
  output logic                               o_rate_ack,
  output logic                               o_rate_err,
  output logic [2:0]                         o_tx_clk_sel,
  output logic                               o_tx_clk_en,
  output logic                               o_clk_ready,
  output logic                               o_fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]     o_retry_cnt,
  output logic [2:0]                         o_state
);

  localparam int CNT_MAX = max_of(max_of(RST_CYCLES, LOCK_TIMEOUT), max_of(LOCK_STABLE, GATE_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RTY_W-1:0] rty_t;

  localparam cnt_t RST_LAST    = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t TO_LAST     = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST = cnt_t'(LOCK_STABLE - 1);
  localparam cnt_t GATE_LAST   = cnt_t'(GATE_CYCLES - 1);
  localparam rty_t RTY_LIMIT   = rty_t'(MAX_RETRY);
  localparam logic [2:0] SEL_RST = 3'(DEFAULT_SEL);

  pll_state_e r_state, w_state;
  cnt_t       r_cnt, w_cnt, w_cnt_inc;
  rty_t       r_retry, w_retry;
  logic [2:0] r_pend, w_pend;
  logic [2:0] r_sel, w_sel;
  logic       r_pll_rst, w_pll_rst;
  logic       r_en, w_en;
  logic       r_ready, w_ready;
  logic       r_ack, w_ack;
  logic       r_err, w_err;
  logic       r_fault, w_fault;
  logic       w_lock;

  spw_sync_2ff u_lock_sync (
    .i_clk   (i_refclk),
    .i_rst   (i_rst),
    .i_async (i_pll_locked),
    .o_sync  (w_lock)
  );

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_pend    <= SEL_RST;
      r_sel     <= SEL_RST;
      r_pll_rst <= 1'b1;
      r_en      <= 1'b0;
      r_ready   <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_retry   <= w_retry;
      r_pend    <= w_pend;
      r_sel     <= w_sel;
      r_pll_rst <= w_pll_rst;
      r_en      <= w_en;
      r_ready   <= w_ready;
      r_ack     <= w_ack;
      r_err     <= w_err;
      r_fault   <= w_fault;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + cnt_t'(1);
    w_cnt     = r_cnt;
    w_retry   = r_retry;
    w_pend    = r_pend;
    w_sel     = r_sel;
    w_pll_rst = r_pll_rst;
    w_en      = r_en;
    w_ready   = r_ready;
    w_ack     = 1'b0;
    w_err     = 1'b0;
    w_fault   = r_fault;

    case (r_state)
      RESET_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_state   = WAIT_LOCK;
          w_cnt     = '0;
          w_pll_rst = 1'b0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (w_lock) begin
          w_state = STABLE_CHK;
          w_cnt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_retry   = r_retry + rty_t'(1);
          w_cnt     = '0;
          w_pll_rst = 1'b1;
          if (w_retry == RTY_LIMIT) begin
            w_state = FAULT;
            w_fault = 1'b1;
          end else begin
            w_state = RESET_PLL;
          end
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      STABLE_CHK: begin
        if (!w_lock) begin
          w_state = WAIT_LOCK;
          w_cnt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state = RUN;
          w_cnt   = '0;
          w_retry = '0;
          w_en    = 1'b1;
          w_ready = 1'b1;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      RUN: begin
        if (i_rate_req) begin
          if (i_rate_sel > SEL_LAST) begin
            w_ack = 1'b1;
            w_err = 1'b1;
          end else if (i_rate_sel == r_sel) begin
            w_ack = 1'b1;
          end else begin
            w_pend  = i_rate_sel;
            w_state = GATE;
            w_cnt   = '0;
            w_en    = 1'b0;
            w_ready = 1'b0;
          end
        end
      end
      GATE: begin
        if (r_cnt == GATE_LAST) begin
          w_state = SWITCH;
          w_cnt   = '0;
          w_sel   = r_pend;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      SWITCH: begin
        w_state = SETTLE;
        w_cnt   = '0;
      end
      SETTLE: begin
        if (r_cnt == GATE_LAST) begin
          w_state = RUN;
          w_cnt   = '0;
          w_en    = 1'b1;
          w_ready = 1'b1;
          w_ack   = 1'b1;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_pll_rst = 1'b1;
        w_en      = 1'b0;
        w_ready   = 1'b0;
        w_fault   = 1'b1;
        w_ack     = i_rate_req;
        w_err     = i_rate_req;
      end
    endcase

    // Lock loss outranks every transition above; the select is never touched here.
    if (!w_lock && (r_state inside {RUN, GATE, SWITCH, SETTLE})) begin
      w_state   = RESET_PLL;
      w_cnt     = '0;
      w_pll_rst = 1'b1;
      w_en      = 1'b0;
      w_ready   = 1'b0;
      w_sel     = r_sel;
      w_pend    = r_pend;
      w_ack     = (r_state != RUN) || i_rate_req;
      w_err     = (r_state != RUN) || i_rate_req;
    end
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_rate_ack   = r_ack;
  assign o_rate_err   = r_err;
  assign o_tx_clk_sel = r_sel;
  assign o_tx_clk_en  = r_en;
  assign o_clk_ready  = r_ready;
  assign o_fault      = r_fault;
  assign o_retry_cnt  = r_retry;
  assign o_state      = r_state;

endmodule
